// File: rtl/alu_test_sequencer.sv
`default_nettype none
// ============================================================================
// alu_test_sequencer: walks an operand ROM through a function unit, folding results into status.
// Revision: 1.0
// ============================================================================
module alu_test_sequencer #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [3:0]    i_fs_sel,
  output logic [AW-1:0] o_rom_addr,
  input  logic [15:0]   i_rom_data,
  output logic [7:0]    o_opa,
  output logic [7:0]    o_opb,
  output logic [3:0]    o_fs,
  input  logic [7:0]    i_result,
  input  logic          i_v,
  input  logic          i_c,
  input  logic          i_n,
  input  logic          i_z,
  output logic [7:0]    o_last_result,
  output logic [3:0]    o_flags_sticky,
  output logic [AW:0]   o_zero_count,
  output logic [7:0]    o_checksum,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] c_last_addr = {AW{1'b1}};
  localparam logic [AW-1:0] c_addr_one  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   c_zc_one    = {{AW{1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_rom_addr;
  logic [7:0]    r_opa;
  logic [7:0]    r_opb;
  logic [3:0]    r_fs;
  logic [7:0]    r_last_result;
  logic [3:0]    r_flags_sticky;
  logic [AW:0]   r_zero_count;
  logic [7:0]    r_checksum;
  logic          w_last_entry;

  assign w_last_entry = (r_rom_addr == c_last_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_CAPT;
      S_CAPT:  w_next = w_last_entry ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ROM address is held through FETCH/LOAD so the synchronous ROM output stays aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr     <= '0;
      r_opa          <= '0;
      r_opb          <= '0;
      r_fs           <= '0;
      r_last_result  <= '0;
      r_flags_sticky <= '0;
      r_zero_count   <= '0;
      r_checksum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fs           <= i_fs_sel;
            r_rom_addr     <= '0;
            r_last_result  <= '0;
            r_flags_sticky <= '0;
            r_zero_count   <= '0;
            r_checksum     <= '0;
          end
        end
        S_LOAD: begin
          r_opa <= i_rom_data[15:8];
          r_opb <= i_rom_data[7:0];
        end
        S_CAPT: begin
          r_last_result  <= i_result;
          r_flags_sticky <= r_flags_sticky | {i_v, i_c, i_n, i_z};
          if (i_z) r_zero_count <= r_zero_count + c_zc_one;
          r_checksum     <= r_checksum + i_result;
          if (!w_last_entry) r_rom_addr <= r_rom_addr + c_addr_one;
        end
        default: ;
      endcase
    end
  end

  assign o_rom_addr     = r_rom_addr;
  assign o_opa          = r_opa;
  assign o_opb          = r_opb;
  assign o_fs           = r_fs;
  assign o_last_result  = r_last_result;
  assign o_flags_sticky = r_flags_sticky;
  assign o_zero_count   = r_zero_count;
  assign o_checksum     = r_checksum;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);

endmodule
`default_nettype wire
